result_collector: RTL and testbench

// - Downstream stage of systolic_array_frame. Captures per-column results that leave the

---
 rtl/result_collector.sv | 156 +++++++++++++++
 tb/tb_result_collector.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/result_collector.sv
// Re-aligns skewed per-column results into rows, buffers them in a credit-guarded FIFO,
// drains them via valid/ready. Define COLLECTOR_TLAST_EN to add the out_last tile marker.
module result_collector #(
  parameter int unsigned MATRIX_SIZE = 2,
  parameter int unsigned DATA_SIZE   = 32,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] result_in,
  output logic                                  in_ready,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] row_out,
  output logic [$clog2(FIFO_DEPTH):0]           fill_count,
`ifdef COLLECTOR_TLAST_EN
  output logic                                  out_last,
`endif
  output logic                                  overflow
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned TW = MATRIX_SIZE - 1;

  typedef logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] row_t;

  row_t          mem [FIFO_DEPTH];
  row_t          aligned;
  row_t          head_nxt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_nxt;
  logic [CW-1:0] count_nxt;
  logic [TW-1:0] tag;
  logic [SW-1:0] pending;
  logic          accept;
  logic          push;
  logic          pop;

  // Column j waits MATRIX_SIZE-1-j cycles so all columns line up with the last one.
  for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_col
    localparam int unsigned DEPTH = MATRIX_SIZE - 32'(j) - 1;
    if (DEPTH == 0) begin : g_pass
      assign aligned[j] = result_in[j];
    end else begin : g_dly
      logic [DEPTH-1:0][DATA_SIZE-1:0] stage;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stage <= '0;
        end else begin
          stage[0] <= result_in[j];
          for (int k = 1; k < int'(DEPTH); k++) begin
            stage[k] <= stage[k-1];
          end
        end
      end
      assign aligned[j] = stage[DEPTH-1];
    end
  end

  // Valid tag shadows the deskew line; only accepted rows inject a tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag <= '0;
    end else begin
      tag[0] <= accept;
      for (int k = 1; k < int'(TW); k++) begin
        tag[k] <= tag[k-1];
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int k = 0; k < int'(TW); k++) begin
      pending = pending + SW'(tag[k]);
    end
  end

  // Credit check uses registered state only; a pop in this cycle is not counted.
  assign in_ready = (SW'(fill_count) + pending) < SW'(FIFO_DEPTH);
  assign accept   = in_valid && in_ready;
  assign push     = tag[TW-1];
  assign pop      = out_valid && out_ready;

  always_comb begin
    count_nxt = fill_count;
    case ({push, pop})
      2'b10:   count_nxt = fill_count + CW'(1);
      2'b01:   count_nxt = fill_count - CW'(1);
      default: count_nxt = fill_count;
    endcase
  end

  assign rd_ptr_nxt = pop ? rd_ptr + PW'(1) : rd_ptr;

  // If the FIFO drains to empty this edge, the incoming row becomes the head directly.
  assign head_nxt = (push && ((fill_count - CW'(pop)) == CW'(0))) ? aligned : mem[rd_ptr_nxt];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= aligned;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_count <= '0;
      out_valid  <= 1'b0;
      row_out    <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr     <= rd_ptr_nxt;
      fill_count <= count_nxt;
      out_valid  <= (count_nxt != CW'(0));
      row_out    <= (count_nxt != CW'(0)) ? head_nxt : '0;
      if (in_valid && !in_ready) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef COLLECTOR_TLAST_EN
  localparam int unsigned PCW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;

  logic [PCW-1:0] pop_cnt;
  logic [PCW-1:0] pop_cnt_nxt;

  // Counts popped rows modulo MATRIX_SIZE; the head is last when it completes a tile.
  always_comb begin
    pop_cnt_nxt = pop_cnt;
    if (pop) begin
      pop_cnt_nxt = (pop_cnt == PCW'(MATRIX_SIZE - 1)) ? '0 : pop_cnt + PCW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_cnt  <= '0;
      out_last <= 1'b0;
    end else begin
      pop_cnt  <= pop_cnt_nxt;
      out_last <= (count_nxt != CW'(0)) && (pop_cnt_nxt == PCW'(MATRIX_SIZE - 1));
    end
  end
`endif

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector (MATRIX_SIZE=2, DATA_SIZE=32, FIFO_DEPTH=4).
// Checks out_last as well when built with COLLECTOR_TLAST_EN.
module tb_result_collector;

  localparam int unsigned MS = 2;
  localparam int unsigned DS = 32;
  localparam int unsigned FD = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 out_ready = 1'b0;
  logic [MS-1:0][DS-1:0] result_in = '0;
  logic                 in_ready;
  logic                 out_valid;
  logic [MS-1:0][DS-1:0] row_out;
  logic [$clog2(FD):0]  fill_count;
  logic                 overflow;
`ifdef COLLECTOR_TLAST_EN
  logic                 out_last;
`endif

  int vectors = 0;
  int miscompares = 0;

  result_collector #(.MATRIX_SIZE(MS), .DATA_SIZE(DS), .FIFO_DEPTH(FD)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .result_in  (result_in),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .row_out    (row_out),
    .fill_count (fill_count),
`ifdef COLLECTOR_TLAST_EN
    .out_last   (out_last),
`endif
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] c0(input int k);
    return 32'h1100_0000 + 32'(k);
  endfunction

  function automatic logic [31:0] c1(input int k);
    return 32'h2200_0000 + 32'(k);
  endfunction

  initial begin
    logic exp_v;

    // Reset state
    tick();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_fill", 64'(fill_count), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_row_out", 64'(row_out), 64'(0));
    reset = 1'b0;

    // Single row: 0x11 then 0x22 one cycle later
    out_ready = 1'b1;
    in_valid = 1'b1;
    result_in[0] = 32'h11;
    result_in[1] = 32'h0;
    check("single_ready_c0", 64'(in_ready), 64'(1));
    check("single_valid_c0", 64'(out_valid), 64'(0));
    tick();
    in_valid = 1'b0;
    result_in[0] = 32'h0;
    result_in[1] = 32'h22;
    check("single_valid_c1", 64'(out_valid), 64'(0));
    tick();
    result_in = '0;
    check("single_valid_c2", 64'(out_valid), 64'(1));
    check("single_row_c2", 64'(row_out), {32'h22, 32'h11});
    check("single_fill_c2", 64'(fill_count), 64'(1));
    tick();
    check("single_valid_c3", 64'(out_valid), 64'(0));
    check("single_fill_c3", 64'(fill_count), 64'(0));

    // Fresh reset so the tile counter starts at zero
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Streaming: rows 1..8 on consecutive cycles
    for (int i = 0; i < 11; i++) begin
      in_valid = (i < 8);
      result_in[0] = (i < 8) ? c0(i + 1) : 32'h0;
      result_in[1] = (i >= 1 && i <= 8) ? c1(i) : 32'h0;
      exp_v = (i >= 2 && i <= 9);
      check("stream_valid", 64'(out_valid), 64'(exp_v));
      if (exp_v) check("stream_row", 64'(row_out), {c1(i - 1), c0(i - 1)});
      check("stream_fill", 64'(fill_count), 64'(exp_v));
      if (i < 8) check("stream_ready", 64'(in_ready), 64'(1));
`ifdef COLLECTOR_TLAST_EN
      check("stream_last", 64'(out_last), 64'(exp_v && ((i - 1) % 2 == 0)));
`endif
      tick();
    end
    check("stream_overflow", 64'(overflow), 64'(0));

    // Backpressure: four rows 11..14 with out_ready low
    out_ready = 1'b0;
    for (int b = 0; b < 5; b++) begin
      in_valid = (b < 4);
      result_in[0] = (b < 4) ? c0(11 + b) : 32'h0;
      result_in[1] = (b >= 1) ? c1(10 + b) : 32'h0;
      check("bp_ready", 64'(in_ready), 64'(b < 4));
      check("bp_fill", 64'((b < 2) ? 0 : b - 1), 64'(fill_count) ^ 64'(0));
      check("bp_valid", 64'(out_valid), 64'(b >= 2));
      if (b >= 2) check("bp_row_hold", 64'(row_out), {c1(11), c0(11)});
      tick();
    end

    // Overflow: push while full
    in_valid = 1'b1;
    result_in[0] = 32'hDEAD;
    result_in[1] = 32'h0;
    check("ovf_ready", 64'(in_ready), 64'(0));
    check("ovf_fill_full", 64'(fill_count), 64'(4));
    check("ovf_before", 64'(overflow), 64'(0));
    tick();
    in_valid = 1'b0;
    result_in[0] = 32'h0;
    result_in[1] = 32'hBEEF;
    check("ovf_after", 64'(overflow), 64'(1));
    check("ovf_fill_kept", 64'(fill_count), 64'(4));
    check("ovf_head_valid", 64'(out_valid), 64'(1));
    check("ovf_head_row", 64'(row_out), {c1(11), c0(11)});
`ifdef COLLECTOR_TLAST_EN
    check("drain_last_0", 64'(out_last), 64'(0));
`endif
    out_ready = 1'b1;
    tick();
    result_in = '0;

    // Drain in order
    for (int d = 1; d <= 4; d++) begin
      check("drain_valid", 64'(out_valid), 64'(d < 4));
      if (d < 4) check("drain_row", 64'(row_out), {c1(11 + d), c0(11 + d)});
      check("drain_fill", 64'(fill_count), 64'(4 - d));
      check("drain_ready", 64'(in_ready), 64'(1));
`ifdef COLLECTOR_TLAST_EN
      if (d < 4) check("drain_last", 64'(out_last), 64'(d % 2 == 1));
`endif
      tick();
    end
    check("drain_overflow_sticky", 64'(overflow), 64'(1));

    // Reset mid-operation: two rows stored, one in flight
    out_ready = 1'b0;
    for (int x = 0; x < 3; x++) begin
      in_valid = 1'b1;
      result_in[0] = c0(31 + x);
      result_in[1] = (x >= 1) ? c1(30 + x) : 32'h0;
      tick();
    end
    in_valid = 1'b0;
    result_in[0] = 32'h0;
    result_in[1] = c1(33);
    check("midrst_pre_fill", 64'(fill_count), 64'(2));
    check("midrst_pre_valid", 64'(out_valid), 64'(1));
    #1 reset = 1'b1;
    #1;
    check("midrst_valid", 64'(out_valid), 64'(0));
    check("midrst_fill", 64'(fill_count), 64'(0));
    check("midrst_overflow", 64'(overflow), 64'(0));
    check("midrst_row", 64'(row_out), 64'(0));
    tick();
    reset = 1'b0;
    result_in = '0;
    for (int p = 0; p < 4; p++) begin
      check("post_rst_valid", 64'(out_valid), 64'(0));
      check("post_rst_fill", 64'(fill_count), 64'(0));
      check("post_rst_ready", 64'(in_ready), 64'(1));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
